// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core memory-port arbiter: bus records, FSM states and
// the arbiter register record with its reset value.
package mem_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_type;

  localparam int MAX_DSTREAK_DEFAULT = 4;
  localparam int STREAK_W            = 4;

  localparam mem_in_type  MEM_IN_INIT  = '0;
  localparam mem_out_type MEM_OUT_INIT = '0;

  // ibuf/dbuf hold captured requests; req is the registered image driven onto the memory port.
  typedef struct packed {
    arb_state_type         state;
    logic                  pend_i;
    logic                  pend_d;
    logic                  kill;
    logic [STREAK_W-1:0]   streak;
    mem_in_type            ibuf;
    mem_in_type            dbuf;
    mem_in_type            req;
  } arb_reg_type;

  localparam arb_reg_type ARB_REG_INIT = '{
    state:  IDLE,
    pend_i: 1'b0,
    pend_d: 1'b0,
    kill:   1'b0,
    streak: '0,
    ibuf:   MEM_IN_INIT,
    dbuf:   MEM_IN_INIT,
    req:    MEM_IN_INIT
  };

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single core memory port between instruction fetch and the LSU,
// one transaction outstanding, data-first with a bounded instruction starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DSTREAK);

  arb_reg_type r;
  arb_reg_type rin;
  logic        grant_i;
  logic        grant_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r <= ARB_REG_INIT;
    end else begin
      r <= rin;
    end
  end

  always_comb begin
    rin     = r;
    grant_i = 1'b0;
    grant_d = 1'b0;

    unique case (r.state)
      IDLE: begin
        if (r.pend_i && r.pend_d) begin
          if (r.streak >= STREAK_LIMIT) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
        end else if (r.pend_d) begin
          grant_d = 1'b1;
        end else if (r.pend_i) begin
          grant_i = 1'b1;
        end
      end
      BUSY_I: begin
        // A redirect that coincides with the return is too late to kill it.
        if (mem_out.mem_ready) begin
          rin.state = IDLE;
          rin.kill  = 1'b0;
          rin.req   = MEM_IN_INIT;
        end else if (imem_in.mem_valid && imem_in.mem_spec) begin
          rin.kill = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_out.mem_ready) begin
          rin.state = IDLE;
          rin.req   = MEM_IN_INIT;
        end
      end
      default: begin
        rin = ARB_REG_INIT;
      end
    endcase

    if (grant_i) begin
      rin.state         = BUSY_I;
      rin.pend_i        = 1'b0;
      rin.streak        = '0;
      rin.req           = r.ibuf;
      rin.req.mem_valid = 1'b1;
    end

    if (grant_d) begin
      rin.state         = BUSY_D;
      rin.pend_d        = 1'b0;
      rin.streak        = r.pend_i ? streak_inc(r.streak) : '0;
      rin.req           = r.dbuf;
      rin.req.mem_valid = 1'b1;
    end

    // Capture after grant so a request arriving on the grant edge waits one cycle.
    if (imem_in.mem_valid) begin
      rin.pend_i = 1'b1;
      rin.ibuf   = imem_in;
    end

    if (dmem_in.mem_valid) begin
      rin.pend_d = 1'b1;
      rin.dbuf   = dmem_in;
    end
  end

  always_comb begin
    mem_in   = r.req;
    imem_out = MEM_OUT_INIT;
    dmem_out = MEM_OUT_INIT;
    if ((r.state == BUSY_I) && mem_out.mem_ready && !r.kill) begin
      imem_out = mem_out;
    end
    if ((r.state == BUSY_D) && mem_out.mem_ready) begin
      dmem_out = mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model plus a
// scoreboard of expected memory-port transactions in grant order.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    mem_in_type req;
    logic       killed;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  mem_in_type  imem_in;
  mem_in_type  dmem_in;
  mem_in_type  mem_in;
  mem_out_type imem_out;
  mem_out_type dmem_out;
  mem_out_type mem_out;

  int   lat = 1;
  int   cnt;
  int   cycle = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   i_cyc = 0;
  int   d_cyc = 0;
  logic d_out = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  mem_in_type  prev_req;
  mem_out_type exp_i;
  mem_out_type exp_d;
  exp_t e;
  exp_t sb[$];

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .reset   (reset),
    .clock   (clock),
    .imem_in (imem_in),
    .imem_out(imem_out),
    .dmem_in (dmem_in),
    .dmem_out(dmem_out),
    .mem_in  (mem_in),
    .mem_out (mem_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return (addr == 32'h0000_0100) ? 32'h0000_0013 : {addr[15:0], 16'hC0DE};
  endfunction

  function automatic mem_in_type mk_req(input logic instr, input logic spec, input logic fence,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] wstrb);
    mem_in_type q;
    q           = '0;
    q.mem_valid = 1'b1;
    q.mem_instr = instr;
    q.mem_spec  = spec;
    q.mem_fence = fence;
    q.mem_addr  = addr;
    q.mem_wdata = wdata;
    q.mem_wstrb = wstrb;
    return q;
  endfunction

  // Memory answers once valid has been up for lat cycles (lat=1 answers in the issue cycle).
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= 0;
    end else if (!mem_in.mem_valid || mem_out.mem_ready) begin
      cnt <= 0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  always_comb begin
    mem_out           = '0;
    mem_out.mem_ready = mem_in.mem_valid && (cnt == lat - 1);
    if (mem_out.mem_ready) begin
      mem_out.mem_rdata = mem_model(mem_in.mem_addr);
    end
  end

  task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input mem_in_type req, input logic killed);
    exp_t x;
    x.req    = req;
    x.killed = killed;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_output("drain", 96'(sb.size()), 96'd0);
  endtask

  task automatic wait_dready(input int budget);
    int n = 0;
    while (!dmem_out.mem_ready && n < budget) begin
      tick();
      n++;
    end
    check_output("dready_wait", {95'd0, dmem_out.mem_ready}, 96'd1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (dmem_in.mem_valid) begin
        check_output("lsu_protocol", {95'd0, d_out && !dmem_out.mem_ready}, 96'd0);
      end
      if (mem_in.mem_valid && prev_valid && !prev_ready) begin
        check_output("hold_stable", {24'd0, mem_in}, {24'd0, prev_req});
      end
      if (mem_out.mem_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_txn", {24'd0, mem_in}, 96'd0);
        end else begin
          e     = sb.pop_front();
          exp_i = '0;
          exp_d = '0;
          if (e.req.mem_instr) begin
            if (!e.killed) exp_i = {1'b1, mem_model(e.req.mem_addr)};
          end else begin
            exp_d = {1'b1, mem_model(e.req.mem_addr)};
          end
          check_output("req_fields", {24'd0, mem_in}, {24'd0, e.req});
          check_output("imem_resp", {63'd0, imem_out}, {63'd0, exp_i});
          check_output("dmem_resp", {63'd0, dmem_out}, {63'd0, exp_d});
        end
      end else begin
        check_output("idle_imem_out", {63'd0, imem_out}, 96'd0);
        check_output("idle_dmem_out", {63'd0, dmem_out}, 96'd0);
      end
      if (dmem_out.mem_ready) begin
        d_out = 1'b0;
        d_cyc = cycle;
      end
      if (imem_out.mem_ready) i_cyc = cycle;
      if (dmem_in.mem_valid) d_out = 1'b1;
      prev_valid = mem_in.mem_valid;
      prev_ready = mem_out.mem_ready;
      prev_req   = mem_in;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    imem_in = '0;
    dmem_in = '0;
    #1 reset = 1'b0;
    #2;
    check_output("reset_mem_in", {24'd0, mem_in}, 96'd0);
    check_output("reset_imem_out", {63'd0, imem_out}, 96'd0);
    check_output("reset_dmem_out", {63'd0, dmem_out}, 96'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();

    $display("[TB] instruction only");
    lat     = 2;
    imem_in = mk_req(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    push_exp(imem_in, 1'b0);
    tick();
    imem_in = '0;
    check_output("lat_captured_only", {95'd0, mem_in.mem_valid}, 96'd0);
    tick();
    check_output("lat_issued", {95'd0, mem_in.mem_valid}, 96'd1);
    wait_drain(20);

    $display("[TB] simultaneous requests");
    lat     = 1;
    imem_in = mk_req(1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 1'b0, 32'h0000_8000, 32'h0, 4'h0);
    push_exp(dmem_in, 1'b0);
    push_exp(imem_in, 1'b0);
    tick();
    imem_in = '0;
    dmem_in = '0;
    wait_drain(20);
    check_output("d_before_i_gap", 96'(i_cyc - d_cyc), 96'd2);

    $display("[TB] starvation guard");
    imem_in = mk_req(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 1'b0, 1'b0, 32'h0000_9000, 32'h0, 4'h0);
    push_exp(dmem_in, 1'b0);
    tick();
    imem_in = '0;
    dmem_in = '0;
    for (int k = 1; k < 5; k++) begin
      wait_dready(20);
      dmem_in = mk_req(1'b0, 1'b0, 1'b0, 32'h0000_9000 + 32'(4 * k), 32'h0, 4'h0);
      if (k == 4) push_exp(mk_req(1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0), 1'b0);
      push_exp(dmem_in, 1'b0);
      tick();
      dmem_in = '0;
    end
    wait_drain(30);

    $display("[TB] speculative kill");
    lat     = 3;
    imem_in = mk_req(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    push_exp(imem_in, 1'b1);
    tick();
    imem_in = '0;
    tick();
    imem_in = mk_req(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    push_exp(imem_in, 1'b0);
    tick();
    imem_in = '0;
    wait_drain(30);

    $display("[TB] redirect coincident with return");
    lat     = 1;
    imem_in = mk_req(1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    push_exp(imem_in, 1'b0);
    tick();
    imem_in = '0;
    tick();
    check_output("coincident_ready", {95'd0, imem_out.mem_ready}, 96'd1);
    imem_in = mk_req(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    push_exp(imem_in, 1'b0);
    tick();
    imem_in = '0;
    wait_drain(20);

    $display("[TB] store passthrough");
    lat     = 3;
    dmem_in = mk_req(1'b0, 1'b0, 1'b0, 32'h0000_8004, 32'hDEAD_BEEF, 4'hF);
    push_exp(dmem_in, 1'b0);
    tick();
    dmem_in = '0;
    wait_drain(20);

    $display("[TB] reset mid-flight");
    lat     = 5;
    dmem_in = mk_req(1'b0, 1'b0, 1'b0, 32'h0000_8008, 32'h0, 4'h0);
    push_exp(dmem_in, 1'b0);
    tick();
    dmem_in = '0;
    tick();
    tick();
    check_output("busy_before_reset", {95'd0, mem_in.mem_valid}, 96'd1);
    #2 reset = 1'b0;
    #1;
    check_output("async_mem_in", {24'd0, mem_in}, 96'd0);
    check_output("async_dmem_out", {63'd0, dmem_out}, 96'd0);
    check_output("async_imem_out", {63'd0, imem_out}, 96'd0);
    sb.delete();
    d_out = 1'b0;
    tick();
    reset = 1'b1;
    repeat (8) tick();
    check_output("post_reset_idle", {24'd0, mem_in}, 96'd0);
    wait_drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory port between two requesters: the instruction fetchbuffer (instruction side) and the load/store unit (data side).
- Sits between those two requesters and the memory/bus interface.
- Only one transaction is outstanding at a time. Data has priority over instructions, with a bounded starvation guard for instructions.
- Honours speculative redirects: when the fetch stream is redirected, an in-flight instruction response is killed.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while an instruction request is waiting. Legal range 1..15.

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  single clock, rising edge
- imem_in  input  mem_in_type  instruction-side request. Fields: mem_valid, mem_fence, mem_spec, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]
- imem_out  output  mem_out_type  instruction-side response. Fields: mem_ready, mem_rdata[31:0]
- dmem_in  input  mem_in_type  data-side request
- dmem_out  output  mem_out_type  data-side response
- mem_in  output  mem_in_type  request to the memory port
- mem_out  input  mem_out_type  response from the memory port

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - pend_i, pend_d, kill and streak cleared.
  - All output fields 0: mem_in.mem_valid=0, imem_out.mem_ready=0, dmem_out.mem_ready=0, all rdata 0.
- Capture, per side:
  - x_in.mem_valid=1 at edge t: request fields are latched into that side's holding register and pend_x is set.
  - Instruction side: a new valid overwrites an unissued pend_i (the latest fetch address wins).
  - Data side: the LSU holds off new requests until dmem_out.mem_ready. A dmem valid while pend_d or BUSY_D is a protocol violation; the bench asserts on it.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Both pending: grant D unless streak==MAX_DSTREAK, in which case grant I.
  - Only one side pending: grant that side.
  - Grant moves the FSM to BUSY_x, clears pend_x and registers the request onto mem_in.
  - Grant I clears streak. Grant D while pend_i increments streak (saturating). Grant D with no pend_i clears streak.
- BUSY_x:
  - mem_in.mem_valid=1; all mem_in fields held stable until mem_out.mem_ready.
  - On mem_out.mem_ready the FSM returns to IDLE in the next cycle. Next grant is earliest the cycle after (one idle bubble minimum).
- Response forwarding:
  - While BUSY_x and mem_out.mem_ready=1, x_out.mem_ready=1 and x_out.mem_rdata=mem_out.mem_rdata, combinationally, for that cycle only.
  - The other side's mem_ready=0 and rdata=0.
- Latency:
  - Request captured at edge t, so mem_in.mem_valid=1 from t+1.
  - With single-cycle memory, x_out.mem_ready=1 in cycle t+1.
- Speculation kill:
  - imem_in.mem_valid=1 with mem_spec=1 while BUSY_I: set kill.
  - When the in-flight response returns, imem_out.mem_ready stays 0 and rdata is discarded. Kill clears on that return.
  - The new speculative request stays in pend_i and issues normally afterwards.
  - mem_spec while IDLE or BUSY_D only overwrites pend_i; no kill.
- Fence: mem_fence is latched and forwarded unchanged with the instruction request. The arbiter adds no ordering beyond single-outstanding.
- Simultaneous events:
  - Capture and grant in the same edge: the pending register written at edge t is considered for grant at edge t+1.
  - mem_ready coincident with a new spec request: the response is forwarded (kill not yet set). The new request is still captured.
- Reset mid-transaction: all state is dropped immediately. No response is delivered after reset release, and mem_in.mem_valid falls asynchronously.

Decomposition:
- Existing package: mem_in_type and mem_out_type are reused from wires.
- New in constants: arbiter state enum (IDLE, BUSY_I, BUSY_D) and the default MAX_DSTREAK.
- New in wires: arbiter register record type plus its init constant.
- No sub-module. A single comb/ff pair over the register record, matching the rest of the pipeline.

Test Plan:
- Instruction only: imem valid, addr=0x00000100; memory ready one cycle after mem_valid with rdata=0x00000013 -> mem_in.mem_addr=0x100 and mem_instr=1; imem_out.mem_ready=1 with rdata 0x13 in the same cycle as mem_out.mem_ready.
- Simultaneous: imem addr 0x200 and dmem addr 0x8000 (load) at the same edge, single-cycle memory -> data issued first; instruction issued after the IDLE bubble; dmem_out.mem_ready precedes imem_out.mem_ready by 2 cycles.
- Starvation: MAX_DSTREAK=4, pend_i held while LSU issues back-to-back loads -> exactly 4 data grants, then instruction grant, then streak resets to 0.
- Kill: BUSY_I on 0x300 with 3-cycle memory; spec request to 0x400 in cycle 1 -> the 0x300 response is not forwarded; next mem_in.mem_addr=0x400 and its response is forwarded.
- Store passthrough: dmem addr 0x8004, wdata 0xDEADBEEF, wstrb 0xF -> mem_in carries identical fields, mem_instr=0, held until mem_ready.
- Reset mid-flight: reset low during BUSY_D -> all outputs 0 asynchronously; after release, no stale dmem_out.mem_ready and state is IDLE.
